// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg
//    Shared pipeline constants for the fetch stage and the later stage registers.
//    Also holds the IF/ID update-action encoding and the function that picks the
//    action. The if_id_register sub-module uses both.
//    No ports.
package instruction_fetch_stage_pkg;

   localparam int          DEF_XLEN      = 64;
   localparam int          INSTR_W       = 32;
   localparam logic [63:0] DEF_RESET_PC  = 64'h0;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [1:0] {
      IFID_BUBBLE = 2'd0,
      IFID_HOLD   = 2'd1,
      IFID_LOAD   = 2'd2
   } ifid_action_t;

   // Flush beats stall. A cycle with no valid fetch inserts a bubble.
   function automatic ifid_action_t ifid_action(input logic flush,
                                                input logic stall,
                                                input logic fetch_valid);
      if (flush)
         return IFID_BUBBLE;
      else if (stall)
         return IFID_HOLD;
      else if (fetch_valid)
         return IFID_LOAD;
      else
         return IFID_BUBBLE;
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// if_id_register
//    IF/ID pipeline register. It applies the flush/stall/load/bubble priority and
//    loads the reset values on a synchronous reset.
//    Ports:
//       clk, reset          rising-edge clock, synchronous active-high reset
//       flush, stall        squash / hold requests
//       fetch_valid         fetched instruction valid this cycle
//       fetch_pc            PC of the fetched instruction
//       fetch_instr         fetched instruction word
//       ifid_pc             registered PC
//       ifid_instr          registered instruction
//       ifid_valid          registered valid (0 = bubble)
module if_id_register
   import instruction_fetch_stage_pkg::*;
#(
   parameter int              XLEN      = DEF_XLEN,
   parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                stall,
   input  logic                fetch_valid,
   input  logic [XLEN-1:0]     fetch_pc,
   input  logic [INSTR_W-1:0]  fetch_instr,
   output logic [XLEN-1:0]     ifid_pc,
   output logic [INSTR_W-1:0]  ifid_instr,
   output logic                ifid_valid
);

   ifid_action_t action;

   assign action = ifid_action(flush, stall, fetch_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else begin
         case (action)
            IFID_LOAD: begin
               ifid_pc    <= fetch_pc;
               ifid_instr <= fetch_instr;
               ifid_valid <= 1'b1;
            end
            IFID_HOLD: begin
               ifid_pc    <= ifid_pc;
               ifid_instr <= ifid_instr;
               ifid_valid <= ifid_valid;
            end
            default: begin
               // A bubble never captures fetch_instr, so an X on the imem bus
               // while fetch_valid is low cannot reach ID.
               ifid_pc    <= '0;
               ifid_instr <= NOP_INSTR;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//    IF stage. It holds the PC register and the next-PC select, fetches through
//    a valid-qualified instruction-memory port and feeds the IF/ID register.
//    Ports:
//       clk, reset          rising-edge clock, synchronous active-high reset
//       switch_branch       redirect PC to branch_target (word aligned)
//       Flush               bubble the IF/ID register this edge
//       branch_target       resolved branch target from EX
//       stall               hold PC and IF/ID
//       imem_addr           fetch address, equal to pc combinationally
//       imem_rdata          instruction at imem_addr
//       imem_valid          imem_rdata valid this cycle
//       pc_if               current PC
//       ifid_pc             PC of the instruction in IF/ID
//       ifid_instr          instruction in IF/ID
//       ifid_valid          IF/ID holds a real instruction
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int              XLEN      = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC[XLEN-1:0],
   parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                switch_branch,
   input  logic                Flush,
   input  logic [XLEN-1:0]     branch_target,
   input  logic                stall,
   output logic [XLEN-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_valid,
   output logic [XLEN-1:0]     pc_if,
   output logic [XLEN-1:0]     ifid_pc,
   output logic [INSTR_W-1:0]  ifid_instr,
   output logic                ifid_valid
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;

   // A branch redirect wins over stall. A missing fetch retries the same
   // address. The increment wraps silently at the top of the address space.
   always_comb begin
      pc_next = pc;
      if (switch_branch)
         pc_next = {branch_target[XLEN-1:2], 2'b00};
      else if (!stall && imem_valid)
         pc_next = pc + PC_STEP;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

   assign imem_addr = pc;
   assign pc_if     = pc;

   if_id_register #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_register (
      .clk         (clk),
      .reset       (reset),
      .flush       (Flush),
      .stall       (stall),
      .fetch_valid (imem_valid),
      .fetch_pc    (pc),
      .fetch_instr (imem_rdata),
      .ifid_pc     (ifid_pc),
      .ifid_instr  (ifid_instr),
      .ifid_valid  (ifid_valid)
   );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage
//    Runs directed scenarios and then randomized cycles. Each cycle is compared
//    against a reference model of the fetch stage written from its update rules.
module tb_instruction_fetch_stage;

   localparam logic [63:0] RST_PC = 64'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        switch_branch = 1'b0;
   logic        Flush = 1'b0;
   logic [63:0] branch_target = '0;
   logic        stall = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_valid = 1'b0;
   logic [63:0] pc_if;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [63:0] m_pc;
   logic [63:0] m_ipc;
   logic [31:0] m_instr;
   logic        m_valid;
   bit          m_init = 1'b0;

   always #5 clk = ~clk;

   instruction_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .switch_branch (switch_branch),
      .Flush         (Flush),
      .branch_target (branch_target),
      .stall         (stall),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .pc_if         (pc_if),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bubble_model();
      m_ipc   = 64'h0;
      m_instr = NOP;
      m_valid = 1'b0;
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then
   // checks all outputs 1 time unit after the edge.
   task automatic step(input logic r, input logic sb, input logic fl,
                       input logic [63:0] bt, input logic st, input logic v,
                       input logic [31:0] rd);
      reset         = r;
      switch_branch = sb;
      Flush         = fl;
      branch_target = bt;
      stall         = st;
      imem_valid    = v;
      imem_rdata    = v ? rd : 32'hxxxx_xxxx;
      #1;
      if (m_init) chk("imem_addr", imem_addr, m_pc);
      @(posedge clk);
      if (r) begin
         m_pc = RST_PC;
         bubble_model();
      end else begin
         // IF/ID captures the PC as it was before this edge.
         if (fl)        bubble_model();
         else if (st)   ;
         else if (v)    begin m_ipc = m_pc; m_instr = rd; m_valid = 1'b1; end
         else           bubble_model();
         if (sb)            m_pc = bt & ~64'h3;
         else if (!st && v) m_pc = m_pc + 64'd4;
      end
      m_init = 1'b1;
      #1;
      chk("pc_if",      pc_if,              m_pc);
      chk("ifid_pc",    ifid_pc,            m_ipc);
      chk("ifid_instr", {32'h0, ifid_instr}, {32'h0, m_instr});
      chk("ifid_valid", {63'h0, ifid_valid}, {63'h0, m_valid});
   endtask

   initial begin
      logic [31:0] rd;

      // reset
      step(1, 0, 0, 64'h0, 0, 0, 32'h0);
      chk("rst_pc",    pc_if, 64'h0);
      chk("rst_valid", {63'h0, ifid_valid}, 64'h0);
      chk("rst_instr", {32'h0, ifid_instr}, {32'h0, NOP});
      chk("rst_ifpc",  ifid_pc, 64'h0);

      // sequential fetch
      step(0, 0, 0, 64'h0, 0, 1, 32'hA000_0001);
      chk("seq_pc4", pc_if, 64'h4);   chk("seq_ifpc0", ifid_pc, 64'h0);
      step(0, 0, 0, 64'h0, 0, 1, 32'hA000_0002);
      chk("seq_pc8", pc_if, 64'h8);   chk("seq_ifpc4", ifid_pc, 64'h4);
      step(0, 0, 0, 64'h0, 0, 1, 32'hA000_0003);
      chk("seq_pc12", pc_if, 64'hC);  chk("seq_ifpc8", ifid_pc, 64'h8);
      chk("seq_valid", {63'h0, ifid_valid}, 64'h1);
      step(0, 0, 0, 64'h0, 0, 1, 32'hA000_0004);

      // branch + flush with unaligned target
      step(0, 1, 1, 64'h103, 0, 1, 32'hB000_0000);
      chk("br_pc", pc_if, 64'h100);
      chk("br_valid", {63'h0, ifid_valid}, 64'h0);
      chk("br_instr", {32'h0, ifid_instr}, {32'h0, NOP});
      step(0, 0, 0, 64'h0, 0, 1, 32'hB000_0100);
      chk("br_tgt_ifpc", ifid_pc, 64'h100);

      // stall at 0x20
      step(0, 1, 0, 64'h20, 0, 1, 32'hC000_0000);
      step(0, 0, 0, 64'h0, 1, 1, 32'hC000_0001);
      step(0, 0, 0, 64'h0, 1, 1, 32'hC000_0002);
      chk("stall_pc", pc_if, 64'h20);
      chk("stall_ifpc", ifid_pc, 64'h104);
      step(0, 0, 0, 64'h0, 0, 1, 32'hC000_0020);
      chk("unstall_pc", pc_if, 64'h24);

      // stall + branch + flush
      step(0, 1, 1, 64'h40, 1, 1, 32'hD000_0000);
      chk("stbr_pc", pc_if, 64'h40);
      chk("stbr_valid", {63'h0, ifid_valid}, 64'h0);

      // no valid fetch
      step(0, 0, 0, 64'h0, 0, 0, 32'h0);
      step(0, 0, 0, 64'h0, 0, 0, 32'h0);
      chk("nv_pc", pc_if, 64'h40);
      chk("nv_valid", {63'h0, ifid_valid}, 64'h0);

      // reset while stalled at 0x80
      step(0, 1, 1, 64'h80, 0, 1, 32'hE000_0000);
      step(0, 0, 0, 64'h0, 1, 1, 32'hE000_0001);
      chk("pre_rst_pc", pc_if, 64'h80);
      step(1, 1, 1, 64'h200, 1, 1, 32'hE000_0002);
      chk("midrst_pc", pc_if, RST_PC);
      chk("midrst_valid", {63'h0, ifid_valid}, 64'h0);

      // wrap at top of address space
      step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 32'hF000_0000);
      chk("top_pc", pc_if, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 0, 0, 64'h0, 0, 1, 32'hF000_0001);
      chk("wrap_pc", pc_if, 64'h0);
      chk("wrap_ifpc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // randomized
      for (int i = 0; i < 400; i++) begin
         logic        r, sb, fl, st, v;
         logic [63:0] bt;
         r  = ($urandom_range(0, 49) == 0);
         sb = ($urandom_range(0, 9) == 0);
         fl = sb ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 4) == 0);
         v  = ($urandom_range(0, 3) != 0);
         bt = {$urandom(), $urandom()};
         rd = $urandom();
         step(r, sb, fl, bt, st, v, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
